// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the datapath: fetch in T0-T2, decode ir at T3, then run
// per-opcode execute steps up to T7 before returning to T0. HALT parks until clear.
module control_sequencer #(
    parameter int unsigned IR_W    = 32,
    parameter int unsigned OPC_LSB = 27
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] ir,
    input  logic            con_ff,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            ZLowIn,
    output logic            ZLowOut,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            RCout,
    output logic            CONin,
    output logic [3:0]      alu_op,
    output logic            run
);

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpBrx  = 5'b10010;
    localparam logic [4:0] OpHalt = 5'b11011;

    state_e     state_q, state_d;
    logic [4:0] opc_q, opc;
    logic       is_reg, is_imm, is_ldi, is_ld, is_st, is_brx, is_halt;
    logic [3:0] alu_sel;
    logic       unused_ir;

    // In T3 the opcode comes straight from ir; later steps use the copy latched at the T3 edge.
    assign opc       = (state_q == StT3) ? ir[OPC_LSB +: 5] : opc_q;
    assign unused_ir = ^ir;

    assign is_reg  = (opc == OpAdd) || (opc == OpSub) || (opc == OpAnd) || (opc == OpOr);
    assign is_imm  = (opc == OpAddi) || (opc == OpAndi) || (opc == OpOri);
    assign is_ldi  = (opc == OpLdi);
    assign is_ld   = (opc == OpLd);
    assign is_st   = (opc == OpSt);
    assign is_brx  = (opc == OpBrx);
    assign is_halt = (opc == OpHalt);

    always_comb begin
        alu_sel = 4'b0000;
        if ((opc == OpSub)) alu_sel = 4'b0001;
        if ((opc == OpAnd) || (opc == OpAndi)) alu_sel = 4'b0010;
        if ((opc == OpOr) || (opc == OpOri)) alu_sel = 4'b0011;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (is_halt) state_d = StHalt;
                else if (is_reg || is_imm || is_ldi || is_ld || is_st || is_brx) state_d = StT4;
                else state_d = StT0;
            end
            StT4:   state_d = StT5;
            StT5:   state_d = (is_ld || is_st || is_brx) ? StT6 : StT0;
            StT6:   state_d = (is_ld || is_st) ? StT7 : StT0;
            StT7:   state_d = StT0;
            StHalt: state_d = StHalt;
            default: state_d = StT0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StT0;
            opc_q   <= 5'b11010;
        end else begin
            state_q <= state_d;
            if (state_q == StT3) opc_q <= opc;
        end
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin} = '0;
        {ZLowIn, ZLowOut, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin} = '0;
        alu_op = 4'b0000;
        run    = clear || (state_q != StHalt);
        // Clear forces an idle cycle so an aborted store never leaves Write asserted.
        if (!clear) begin
            unique case (state_q)
                StT0: {PCout, MARin, IncPC} = 3'b111;
                StT1: {Read, MDRin} = 2'b11;
                StT2: {MDRout, IRin} = 2'b11;
                StT3: begin
                    if (is_reg || is_imm) {Grb, Rout, Yin} = 3'b111;
                    else if (is_ldi || is_ld || is_st) {Grb, BAout, Yin} = 3'b111;
                    else if (is_brx) {Gra, Rout, CONin} = 3'b111;
                end
                StT4: begin
                    if (is_reg) begin
                        {Grc, Rout, ZLowIn} = 3'b111;
                        alu_op = alu_sel;
                    end else if (is_imm) begin
                        {RCout, ZLowIn} = 2'b11;
                        alu_op = alu_sel;
                    end else if (is_ldi || is_ld || is_st) begin
                        {RCout, ZLowIn} = 2'b11;
                    end else if (is_brx) begin
                        {PCout, Yin} = 2'b11;
                    end
                end
                StT5: begin
                    if (is_reg || is_imm || is_ldi) {ZLowOut, Gra, Rin} = 3'b111;
                    else if (is_ld || is_st) {ZLowOut, MARin} = 2'b11;
                    else if (is_brx) {RCout, ZLowIn} = 2'b11;
                end
                StT6: begin
                    if (is_ld) {Read, MDRin} = 2'b11;
                    else if (is_st) {Gra, Rout, MDRin} = 3'b111;
                    else if (is_brx && con_ff) {ZLowOut, PCin} = 2'b11;
                end
                StT7: begin
                    if (is_ld) {MDRout, Gra, Rin} = 3'b111;
                    else if (is_st) Write = 1'b1;
                end
                StHalt: ;
                default: ;
            endcase
        end
    end

endmodule
